// File: rtl/dmem_uart_tx_if.sv
// Data-memory bus seen by the UART transmitter: CPU drives we/addr/wdata,
// the responder returns combinational rdata.
interface dmem_uart_tx_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a small TX FIFO,
// a serializer drains it LSB first, and loads return status for polling.
module dmem_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_uart_tx_if.slave bus,
  output logic          tx,
  output logic          tx_idle
);

  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [3:0] sat_count4(input logic [PW:0] cnt);
    logic [31:0] wide;
    wide = 32'(cnt);
    return (wide > 32'd15) ? 4'hF : wide[3:0];
  endfunction

  state_t        r_state, w_state_nxt;
  logic [PW:0]   r_wptr, r_rptr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic          r_ovf;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;

  logic          w_sel, w_push_req, w_push, w_pop, w_ovf_set, w_ovf_clr;
  logic [1:0]    w_idx;
  logic [PW:0]   w_count;
  logic          w_full, w_empty, w_busy, w_baud_last;
  logic [7:0]    w_head;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_idx       = bus.addr[3:2];
  assign w_count     = r_wptr - r_rptr;
  assign w_full      = (w_count == DEPTH_CNT);
  assign w_empty     = (w_count == '0);
  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_head      = r_mem[r_rptr[PW-1:0]];
  assign w_unused    = ^{bus.addr[1:0], bus.wdata[31:8]};

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
  assign w_push_req = bus.we && w_sel && (w_idx == 2'd0);
  assign w_push     = w_push_req && !w_full;
  assign w_ovf_set  = w_push_req && w_full;
  assign w_ovf_clr  = bus.we && w_sel && (w_idx == 2'd1) && bus.wdata[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push)         r_wptr <= r_wptr + 1'b1;
      if (w_pop)          r_rptr <= r_rptr + 1'b1;
      if (w_ovf_set)      r_ovf  <= 1'b1;
      else if (w_ovf_clr) r_ovf  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        // A queued byte chains straight into the next start bit with no idle gap.
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign tx_idle = w_empty && !w_busy;

  assign w_status  = {24'd0, sat_count4(w_count), r_ovf, w_busy, w_empty, w_full};
  assign bus.rdata = (w_sel && (w_idx == 2'd1)) ? w_status : 32'd0;

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Randomized bench for dmem_uart_tx: a frame-timeline model predicts tx,
// tx_idle and STATUS every cycle; a line decoder pins the transmitted bytes.
module tb_dmem_uart_tx;
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam int          C     = 4;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_idle;
  dmem_uart_tx_if bus_if();

  dmem_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .tx(tx), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: queued bytes, plus the byte on the wire and cycles since its start bit began.
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  bit         m_busy = 0;
  bit         m_ovf  = 0;
  int         m_t    = 0;
  bit         mdl_ok = 0;

  function automatic bit in_win(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  always @(posedge clk) begin
    int n;
    bit full0, pop0, preq, clr;
    cyc++;
    if (reset) begin
      m_q.delete();
      m_busy = 0;
      m_ovf  = 0;
      m_t    = 0;
      mdl_ok = 1;
    end else if (mdl_ok) begin
      n     = m_q.size();
      full0 = (n == DEPTH);
      pop0  = (n > 0) && (!m_busy || m_t == 10*C-1);
      preq  = bus_if.we && in_win(bus_if.addr) && bus_if.addr[3:2] == 2'd0;
      clr   = bus_if.we && in_win(bus_if.addr) && bus_if.addr[3:2] == 2'd1 && bus_if.wdata[3];
      if (m_busy) begin
        m_t++;
        if (m_t == 10*C) m_busy = 0;
      end
      if (pop0) begin
        m_byte = m_q.pop_front();
        m_busy = 1;
        m_t    = 0;
      end
      if (preq) begin
        if (full0) m_ovf = 1;
        else       m_q.push_back(bus_if.wdata[7:0]);
      end
      if (clr) m_ovf = 0;
    end
  end

  function automatic logic exp_tx();
    int p;
    if (!m_busy) return 1'b1;
    p = m_t / C;
    if (p == 0) return 1'b0;
    if (p <= 8) return m_byte[p-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] s;
    int n;
    if (!in_win(a) || a[3:2] != 2'd1) return 32'd0;
    n    = m_q.size();
    s    = 32'd0;
    s[0] = (n == DEPTH);
    s[1] = (n == 0);
    s[2] = m_busy;
    s[3] = m_ovf;
    s[7:4] = (n > 15) ? 4'hF : 4'(n);
    return s;
  endfunction

  always @(negedge clk) begin
    if (mdl_ok) begin
      check("tx", {31'd0, tx}, {31'd0, exp_tx()});
      check("tx_idle", {31'd0, tx_idle}, {31'd0, (m_q.size() == 0) && !m_busy});
      check("rdata", bus_if.rdata, exp_rdata(bus_if.addr));
    end
  end

  // Independent line decoder: samples mid-bit, records bytes and start-bit times.
  logic [7:0] rx_q[$];
  int         rx_fall[$];
  logic [7:0] rx_byte;
  bit         rx_busy = 0;
  logic       prev_tx = 1'b1;
  int         rx_t    = 0;

  always @(negedge clk) begin
    int p;
    if (reset) begin
      rx_busy = 0;
      prev_tx = 1'b1;
    end else if (mdl_ok) begin
      if (rx_busy) begin
        rx_t++;
        if (rx_t % C == C/2) begin
          p = rx_t / C;
          if (p >= 1 && p <= 8) rx_byte[p-1] = tx;
          else if (p == 9) begin
            rx_q.push_back(rx_byte);
            rx_busy = 0;
          end
        end
      end else if (prev_tx && !tx) begin
        rx_busy = 1;
        rx_t    = 0;
        rx_fall.push_back(cyc);
      end
      prev_tx = tx;
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus_if.we    = w;
    bus_if.addr  = a;
    bus_if.wdata = d;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, BASE + 32'd4, 32'd0);
  endtask

  initial begin
    logic [39:0] frame55;
    logic [39:0] got;
    logic [7:0]  exp_ovf[5];
    logic [31:0] a;
    int r;

    reset = 1'b1;
    bus_if.we = 1'b0; bus_if.addr = 32'd0; bus_if.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bus_if.addr = BASE + 32'd4;
    @(negedge clk);
    check("reset_status", bus_if.rdata, 32'h0000_0002);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_tx_idle", {31'd0, tx_idle}, 32'd1);

    // Single frame of 0x55: start, LSB-first alternating bits, stop.
    frame55 = 40'b0000_1111_0000_1111_0000_1111_0000_1111_0000_1111;
    rx_q.delete();
    drive(1'b1, BASE, 32'h0000_0055);
    drive(1'b0, BASE + 32'd4, 32'd0);
    got = '0;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      if (i == 0)  check("pre_fall_tx", {31'd0, tx}, 32'd1);
      if (i >= 1 && i <= 40) got[40-i] = tx;
      if (i == 40) check("idle_during_stop", {31'd0, tx_idle}, 32'd0);
      if (i == 41) check("idle_after_frame", {31'd0, tx_idle}, 32'd1);
    end
    check("frame55_hi", {24'd0, got[39:32]}, {24'd0, frame55[39:32]});
    check("frame55_lo", got[31:0], frame55[31:0]);
    check("rx55_n", rx_q.size(), 32'd1);
    if (rx_q.size() == 1) check("rx55", {24'd0, rx_q[0]}, 32'h55);

    // Overflow: 0x10 occupies the serializer, 0x11..0x14 fill the FIFO, 0x15 drops.
    rx_q.delete();
    drive(1'b1, BASE, 32'h10);
    idle_cycles(3);
    for (int b = 8'h11; b <= 8'h15; b++) drive(1'b1, BASE, 32'(b));
    drive(1'b0, BASE + 32'd4, 32'd0);
    @(negedge clk);
    check("status_full_ovf", bus_if.rdata, 32'h0000_004D);
    drive(1'b1, BASE + 32'd4, 32'h8);
    drive(1'b0, BASE + 32'd4, 32'd0);
    @(negedge clk);
    check("ovf_cleared", bus_if.rdata & 32'h8, 32'd0);
    idle_cycles(240);
    exp_ovf = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check("rx_ovf_n", rx_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check("rx_ovf_byte", {24'd0, rx_q[i]}, {24'd0, exp_ovf[i]});

    // Back-to-back frames: second start bit exactly one frame after the first.
    rx_q.delete();
    rx_fall.delete();
    drive(1'b1, BASE, 32'hA0);
    drive(1'b1, BASE, 32'h0F);
    idle_cycles(100);
    check("b2b_n", rx_q.size(), 32'd2);
    if (rx_q.size() == 2) begin
      check("b2b_first", {24'd0, rx_q[0]}, 32'hA0);
      check("b2b_second", {24'd0, rx_q[1]}, 32'h0F);
    end
    if (rx_fall.size() == 2) check("b2b_gap", 32'(rx_fall[1] - rx_fall[0]), 32'd40);
    else check("b2b_falls", rx_fall.size(), 32'd2);

    // Reset while DATA bit 3 of 0x00 is on the line.
    drive(1'b1, BASE, 32'h00);
    idle_cycles(18);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("tx_bit3_low", {31'd0, tx}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rx_fall.delete();
    @(negedge clk);
    check("tx_after_reset", {31'd0, tx}, 32'd1);
    check("status_after_reset", bus_if.rdata, 32'h0000_0002);
    idle_cycles(60);
    check("no_frame_after_reset", rx_fall.size(), 32'd0);

    // Out-of-window and unused-register accesses.
    drive(1'b1, BASE + 32'd16, 32'h77);
    @(negedge clk);
    check("rd_base16", bus_if.rdata, 32'd0);
    drive(1'b1, BASE + 32'd8, 32'h77);
    @(negedge clk);
    check("rd_base8", bus_if.rdata, 32'd0);
    drive(1'b0, BASE + 32'd4, 32'd0);
    @(negedge clk);
    check("status_untouched", bus_if.rdata, 32'h0000_0002);
    idle_cycles(50);
    check("no_frame_oow", rx_fall.size(), 32'd0);

    // Random traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 19);
      a = BASE + {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (r <= 2)       drive(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom);
      else if (r == 3)  drive(1'b1, BASE + 32'd4, $urandom);
      else if (r == 4)  drive(1'b1, a, $urandom);
      else if (r == 5)  drive(1'b1, BASE + 32'd16 * 32'($urandom_range(1, 4)), $urandom);
      else if (r == 6)  drive($urandom_range(0, 1) == 1, $urandom, $urandom);
      else if (r == 18 && $urandom_range(0, 9) == 0) begin
        @(posedge clk);
        #1 reset = 1'b1; bus_if.we = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
      end
      else if (r == 19) idle_cycles(120);
      else              drive(1'b0, (r < 12) ? BASE + 32'd4 : a, $urandom);
    end
    idle_cycles(250);
    @(negedge clk);
    check("final_idle", {31'd0, tx_idle}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
